// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and word bundle for the SHA-256 fetcher.
// Build option SHA256_FETCH_BSWAP_EN selects little-to-big endian word swap.
package sha256_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam int C_BLK_WORDS = 16;
  localparam int BLK_BYTES   = 64;

  localparam logic [1:0] AXI_INCR   = 2'b01;
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [7:0] AXI_ARLEN  = 8'd15;
  localparam logic [2:0] AXI_ARSIZE = 3'd2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        blk_last;
  } word_t;

  function automatic logic [31:0] bswap32(
    input logic [31:0] d
  );
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/sha256_word_slice.sv
// One-entry valid/ready output register feeding the hash core.
// SHA256_FETCH_BSWAP_EN byte-swaps each word on entry.
module sha256_word_slice
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_last,
  input  logic        i_blk_last,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_blk_last,
  output logic        o_space
);

  word_t       r_word;
  logic        r_valid;
  logic [31:0] w_data;

`ifdef SHA256_FETCH_BSWAP_EN
  assign w_data = bswap32(i_data);
`else
  assign w_data = i_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= '{data: w_data,
                   last: i_last,
                   blk_last: i_blk_last};
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_word.data;
  assign o_last     = r_word.last;
  assign o_blk_last = r_word.blk_last;
  assign o_space    = !r_valid || i_ready;

endmodule

// File: rtl/sha256_blk_fetch.sv
// AXI4 read master streaming 64-byte blocks as 32-bit words to the hash core.
// Build option SHA256_FETCH_BSWAP_EN: byte-swap words (see sha256_word_slice).
module sha256_blk_fetch
  import sha256_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_BLK_WORDS = sha256_pkg::C_BLK_WORDS
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          START,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] SRC_ADDR,
  input  logic [15:0]                   NUM_BLOCKS,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] WORD_DATA,
  output logic                          WORD_VALID,
  input  logic                          WORD_READY,
  output logic                          WORD_LAST,
  output logic                          BLK_LAST
);

  logic [1:0]                    r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [15:0]                   r_blk_rem;
  logic [3:0]                    r_beat;
  logic                          r_err;
  logic                          r_burst_err;
  logic                          r_busy;
  logic                          r_done;

  logic w_space;
  logic w_rbeat;
  logic w_beat_last;
  logic w_beat_err;
  logic w_burst_end;
  logic w_load;
  logic w_unused_addr;

  assign w_unused_addr = ^SRC_ADDR[5:0];

  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = AXI_ARLEN;
  assign M_AXI_ARSIZE  = AXI_ARSIZE;
  assign M_AXI_ARBURST = AXI_INCR;
  assign M_AXI_ARVALID = (r_state == S_ADDR);
  assign M_AXI_RREADY  = (r_state == S_DATA) && w_space;

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

  assign w_rbeat     = M_AXI_RVALID && M_AXI_RREADY;
  assign w_beat_last = (r_beat == 4'(C_BLK_WORDS - 1));
  assign w_beat_err  = (M_AXI_RRESP != AXI_OKAY) ||
                       (M_AXI_RLAST != w_beat_last);
  // an early RLAST still closes the burst
  assign w_burst_end = M_AXI_RLAST || w_beat_last;
  assign w_load      = w_rbeat && !r_burst_err && !w_beat_err;

  sha256_word_slice u_slice (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .i_load     (w_load),
    .i_data     (M_AXI_RDATA),
    .i_last     (w_beat_last),
    .i_blk_last (w_beat_last && (r_blk_rem == 16'd0)),
    .i_ready    (WORD_READY),
    .o_valid    (WORD_VALID),
    .o_data     (WORD_DATA),
    .o_last     (WORD_LAST),
    .o_blk_last (BLK_LAST),
    .o_space    (w_space)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_blk_rem   <= '0;
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_burst_err <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_err       <= 1'b0;
            r_burst_err <= 1'b0;
            r_busy      <= 1'b1;
            if (NUM_BLOCKS != 16'd0) begin
              r_addr    <= {SRC_ADDR[C_M_AXI_ADDR_WIDTH-1:6], 6'b0};
              r_blk_rem <= NUM_BLOCKS - 16'd1;
              r_state   <= S_ADDR;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_beat      <= '0;
            r_burst_err <= 1'b0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_rbeat) begin
            r_beat <= r_beat + 4'd1;
            if (w_beat_err) begin
              r_err       <= 1'b1;
              r_burst_err <= 1'b1;
            end
            if (w_burst_end) begin
              if (r_burst_err || w_beat_err ||
                  r_blk_rem == 16'd0) begin
                r_state <= S_FIN;
              end else begin
                r_addr    <= r_addr + C_M_AXI_ADDR_WIDTH'(BLK_BYTES);
                r_blk_rem <= r_blk_rem - 16'd1;
                r_state   <= S_ADDR;
              end
            end
          end
        end
        S_FIN: begin
          if (w_space) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_blk_fetch.sv
// Scoreboard bench for sha256_blk_fetch with a simple AXI read slave model.
// Honours SHA256_FETCH_BSWAP_EN when computing expected words.
`timescale 1ns/1ps
module tb_sha256_blk_fetch;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        START;
  logic [31:0] SRC_ADDR;
  logic [15:0] NUM_BLOCKS;
  logic        BUSY, DONE, ERR;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] WORD_DATA;
  logic        WORD_VALID, WORD_READY, WORD_LAST, BLK_LAST;

  always #5 ACLK = ~ACLK;

  sha256_blk_fetch dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START),
    .SRC_ADDR(SRC_ADDR), .NUM_BLOCKS(NUM_BLOCKS),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY),
    .WORD_DATA(WORD_DATA), .WORD_VALID(WORD_VALID),
    .WORD_READY(WORD_READY), .WORD_LAST(WORD_LAST),
    .BLK_LAST(BLK_LAST)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done0 = 0;
  int start_cyc = 0;
  int last_word_cyc = 0;
  int n_words = 0;

  logic [33:0] exp_q[$];
  logic [31:0] ar_q[$];

  // slave model configuration
  logic [31:0] mem_base = 0;
  logic [31:0] data_base = 0;
  int  ar_delay = 0;
  bit  gaps = 0;
  bit  rnd_ready = 0;
  int  err_idx = -1;
  int  rlast_idx = -1;

  function automatic logic [31:0] exp_word(logic [31:0] d);
`ifdef SHA256_FETCH_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_words(input logic [31:0] db,
                            input int cnt, input int nblk);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({(i == nblk * 16 - 1), (i % 16 == 15),
                       exp_word(db + 32'(i))});
    end
  endtask

  task automatic push_ars(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) ar_q.push_back(a + 32'(64 * i));
  endtask

  always @(posedge ACLK) cyc++;

  // AXI read slave and consumer-ready generator
  int          s_beat = 0;
  bit          s_act = 0;
  int          s_arcnt = 0;
  logic [31:0] s_addr = 0;
  always begin
    bit ar_hs, r_hs, r_last_s;
    logic [31:0] ar_a;
    int idx;
    @(posedge ACLK);
    ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    r_hs = M_AXI_RVALID && M_AXI_RREADY;
    r_last_s = M_AXI_RLAST;
    ar_a = M_AXI_ARADDR;
    #1;
    WORD_READY = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    if (!ARESETN) begin
      s_act = 0; s_beat = 0; s_arcnt = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
      M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    end else begin
      if (r_hs) begin
        if (r_last_s) s_act = 0;
        else s_beat++;
      end
      if (ar_hs) begin
        s_act = 1; s_addr = ar_a; s_beat = 0;
        M_AXI_ARREADY = 0; s_arcnt = 0;
      end else if (M_AXI_ARVALID && !s_act) begin
        if (s_arcnt >= ar_delay) M_AXI_ARREADY = 1;
        else s_arcnt++;
      end else begin
        M_AXI_ARREADY = 0;
      end
      if (s_act && (!M_AXI_RVALID || r_hs)) begin
        if (!gaps || $urandom_range(1, 0) == 1) begin
          idx = int'((s_addr - mem_base) >> 2) + s_beat;
          M_AXI_RVALID = 1;
          M_AXI_RDATA = data_base + 32'(idx);
          M_AXI_RRESP = (idx == err_idx) ? 2'b10 : 2'b00;
          M_AXI_RLAST = (s_beat == 15) || (idx == rlast_idx);
        end else begin
          M_AXI_RVALID = 0;
        end
      end else if (!s_act) begin
        M_AXI_RVALID = 0;
      end
    end
  end

  // monitors: word scoreboard, AR checks, DONE tracking
  bit          ar_pend = 0;
  logic [31:0] ar_prev = 0;
  bit          done_prev = 0;
  always @(negedge ACLK) begin
    logic [33:0] e;
    if (WORD_VALID && WORD_READY) begin
      n_words++;
      last_word_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL word_extra: got %h expected none", WORD_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", WORD_DATA, e[31:0]);
        chk("word_last", 32'(WORD_LAST), 32'(e[32]));
        chk("blk_last", 32'(BLK_LAST), 32'(e[33]));
      end
    end
    if (WORD_VALID && !WORD_READY)
      chk("rready_stall", 32'(M_AXI_RREADY), 0);
    if (ar_pend && M_AXI_ARVALID)
      chk("araddr_stable", M_AXI_ARADDR, ar_prev);
    ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
    ar_prev = M_AXI_ARADDR;
    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
      if (ar_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL ar_extra: got %h expected none", M_AXI_ARADDR);
      end else begin
        chk("araddr", M_AXI_ARADDR, ar_q.pop_front());
      end
      chk("arlen", 32'(M_AXI_ARLEN), 15);
    end
    if (DONE) begin
      chk("done_width", 32'(done_prev), 0);
      done_cnt++;
      done_cyc = cyc;
    end
    done_prev = DONE;
  end

  task automatic start_op(input logic [31:0] a, input logic [15:0] n);
    done0 = done_cnt;
    SRC_ADDR = a; NUM_BLOCKS = n; START = 1;
    start_cyc = cyc;
    @(posedge ACLK); #1;
    START = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == done0; k++) begin
      @(posedge ACLK); #1;
    end
    chk("done_seen", 32'(done_cnt != done0), 1);
  endtask

  task automatic end_checks(input logic e);
    chk("err_flag", 32'(ERR), 32'(e));
    chk("busy_idle", 32'(BUSY), 0);
    chk("words_left", 32'(exp_q.size()), 0);
    chk("ars_left", 32'(ar_q.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ARESETN = 0; START = 0; SRC_ADDR = 0; NUM_BLOCKS = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("rst_araddr", M_AXI_ARADDR, 0);
    chk("rst_rready", 32'(M_AXI_RREADY), 0);
    chk("rst_wvalid", 32'(WORD_VALID), 0);
    chk("rst_wdata", WORD_DATA, 0);
    chk("rst_wlast", 32'(WORD_LAST), 0);
    chk("rst_blast", 32'(BLK_LAST), 0);
    chk("rst_arlen", 32'(M_AXI_ARLEN), 15);
    chk("rst_arsize", 32'(M_AXI_ARSIZE), 2);
    chk("rst_arburst", 32'(M_AXI_ARBURST), 1);
    ARESETN = 1;
    repeat (2) @(posedge ACLK);
    #1;

    // single block, words 0..15
    mem_base = 32'h1000_0000; data_base = 0;
    push_ars(32'h1000_0000, 1);
    push_words(0, 16, 1);
    start_op(32'h1000_0000, 16'd1);
    wait_done(500);
    chk("done_lat", 32'(done_cyc - last_word_cyc), 1);
    end_checks(1'b0);

    // three blocks from an unaligned address
    mem_base = 32'h2000_0000; data_base = 32'hA000_0000;
    push_ars(32'h2000_0000, 3);
    push_words(32'hA000_0000, 48, 3);
    start_op(32'h2000_0023, 16'd3);
    wait_done(1000);
    end_checks(1'b0);

    // back-pressure, slow ARREADY, RVALID gaps
    mem_base = 32'h3000_0000; data_base = 32'h3300_0000;
    ar_delay = 5; gaps = 1; rnd_ready = 1;
    push_ars(32'h3000_0000, 2);
    push_words(32'h3300_0000, 32, 2);
    start_op(32'h3000_0000, 16'd2);
    wait_done(2000);
    end_checks(1'b0);
    ar_delay = 0; gaps = 0; rnd_ready = 0;

    // SLVERR on beat 4 of the first of two blocks
    mem_base = 32'h3800_0000; data_base = 32'h0000_5000;
    err_idx = 4;
    push_ars(32'h3800_0000, 1);
    push_words(32'h0000_5000, 4, 2);
    start_op(32'h3800_0000, 16'd2);
    wait_done(500);
    repeat (10) @(posedge ACLK);
    #1;
    end_checks(1'b1);
    err_idx = -1;

    // RLAST early on beat 9
    rlast_idx = 9;
    push_ars(32'h3800_0000, 1);
    push_words(32'h0000_5000, 9, 2);
    start_op(32'h3800_0000, 16'd2);
    wait_done(500);
    repeat (10) @(posedge ACLK);
    #1;
    end_checks(1'b1);
    rlast_idx = -1;

    // zero blocks; a START while busy is ignored
    start_op(32'h6000_0000, 16'd0);
    chk("zero_err_clr", 32'(ERR), 0);
    chk("zero_busy", 32'(BUSY), 1);
    NUM_BLOCKS = 16'd1; START = 1;
    @(posedge ACLK); #1;
    START = 0;
    wait_done(50);
    chk("zero_done_lat", 32'(done_cyc - start_cyc), 2);
    repeat (30) @(posedge ACLK);
    #1;
    chk("zero_done_cnt", 32'(done_cnt - done0), 1);
    end_checks(1'b0);

    // reset in the middle of a burst
    mem_base = 32'h4000_0000; data_base = 32'h1111_0000;
    push_ars(32'h4000_0000, 2);
    push_words(32'h1111_0000, 32, 2);
    n_words = 0;
    start_op(32'h4000_0000, 16'd2);
    for (int k = 0; k < 200 && n_words < 7; k++) begin
      @(posedge ACLK); #1;
    end
    chk("mid_words", 32'(n_words >= 7), 1);
    ARESETN = 0;
    #1;
    chk("mrst_busy", 32'(BUSY), 0);
    chk("mrst_arvalid", 32'(M_AXI_ARVALID), 0);
    chk("mrst_rready", 32'(M_AXI_RREADY), 0);
    chk("mrst_wvalid", 32'(WORD_VALID), 0);
    chk("mrst_wdata", WORD_DATA, 0);
    chk("mrst_araddr", M_AXI_ARADDR, 0);
    exp_q.delete();
    ar_q.delete();
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1;
    repeat (2) @(posedge ACLK);
    #1;
    mem_base = 32'h5000_0000; data_base = 32'h0403_0201;
    push_ars(32'h5000_0000, 1);
    push_words(32'h0403_0201, 16, 1);
    start_op(32'h5000_0000, 16'd1);
    wait_done(500);
    end_checks(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
